// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises datapath instruction fetches and data
// loads/stores onto a single RAM port. Data has priority, but a pending
// fetch wins once after each data access. A RAM that never answers
// raises a sticky error instead of deadlocking the datapath.
module memory_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        halted,
  output logic        mem_err
);

  localparam logic [1:0]  RAM_ACCESS   = 2'd2;
  localparam logic [31:0] TIMEOUT_WORD = 32'hBAD1_BAD1;
  localparam int          CNT_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    IREQ,
    DREQ,
    IRESP,
    DRESP,
    HALT
  } state_t;

  state_t           state;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic             req_we;
  logic [CNT_W-1:0] wcnt;
  logic             last_was_data;

  logic ram_ready;
  logic wait_done;
  logic data_pending;
  logic data_grant;

  // Request qualification for the IDLE decision and wait-limit detection
  always_comb begin
    ram_ready    = (ramstate == RAM_ACCESS);
    wait_done    = (wcnt == WAIT_LAST);
    data_pending = dmemREN | dmemWEN;
    // A fetch that was held back by the previous data access goes first.
    data_grant   = data_pending & ~(last_was_data & imemREN);
  end

  // Arbiter FSM: grant, wait for RAM, return one hit, or halt for good
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state         <= IDLE;
      req_addr      <= '0;
      req_data      <= '0;
      req_we        <= 1'b0;
      wcnt          <= '0;
      last_was_data <= 1'b0;
      imemload      <= '0;
      dmemload      <= '0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state <= HALT;
          end else if (data_grant) begin
            req_addr <= dmemaddr;
            req_data <= dmemstore;
            req_we   <= dmemWEN;
            wcnt     <= '0;
            state    <= DREQ;
          end else if (imemREN) begin
            req_addr <= imemaddr;
            req_we   <= 1'b0;
            wcnt     <= '0;
            state    <= IREQ;
          end
        end
        IREQ: begin
          if (ram_ready) begin
            imemload <= ramload;
            state    <= IRESP;
          end else if (wait_done) begin
            // RAM never answered: abandon the fetch but still hand back a word.
            mem_err  <= 1'b1;
            imemload <= TIMEOUT_WORD;
            state    <= IRESP;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        DREQ: begin
          if (ram_ready) begin
            if (!req_we) begin
              dmemload <= ramload;
            end
            state <= DRESP;
          end else if (wait_done) begin
            mem_err  <= 1'b1;
            dmemload <= TIMEOUT_WORD;
            state    <= DRESP;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        IRESP: begin
          last_was_data <= 1'b0;
          state         <= IDLE;
        end
        DRESP: begin
          last_was_data <= 1'b1;
          state         <= IDLE;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM strobes and hit pulses decode straight from the state register,
  // so an asynchronous reset drops them without waiting for a clock edge.
  always_comb begin
    ihit     = (state == IRESP);
    dhit     = (state == DRESP);
    halted   = (state == HALT);
    ramREN   = (state == IREQ) | ((state == DREQ) & ~req_we);
    ramWEN   = (state == DREQ) & req_we;
    ramaddr  = ((state == IREQ) || (state == DREQ)) ? req_addr : 32'h0;
    ramstore = (state == DREQ) ? req_data : 32'h0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a behavioural RAM responder plus a
// transaction-level reference model (memory contents, fairness order,
// latency formula) checked against the arbiter's hits and RAM traffic.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ihit, dhit, ramREN, ramWEN, halted, mem_err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic [31:0] ramload = 32'h0;
  logic [1:0]  ramstate = 2'd0;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } ram_op_t;

  // RAM environment
  logic [31:0] ram_mem [logic [31:0]];
  int          ram_wait = 0;
  int          ram_cnt  = 0;
  bit          ram_errs = 1'b0;
  ram_op_t     ram_log [$];
  ram_op_t     resp_op;

  // Reference model
  logic [31:0] ref_mem [logic [31:0]];
  logic        model_last_data;
  logic [31:0] model_iload, model_dload;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // RAM responder: ram_wait non-ACCESS cycles, then one ACCESS cycle
  always @(negedge CLK) begin
    if (nRST || !(ramREN || ramWEN)) begin
      ram_cnt  = 0;
      ramstate = RS_FREE;
      ramload  = $urandom;
    end else if (ram_cnt < ram_wait) begin
      ram_cnt++;
      ramstate = (ram_errs && $urandom_range(0, 3) == 0) ? RS_ERROR : RS_BUSY;
      ramload  = $urandom;
    end else begin
      ramstate = RS_ACCESS;
      if (ramWEN) begin
        ram_mem[ramaddr] = ramstore;
        ramload = $urandom;
      end else begin
        ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
      end
      resp_op.addr = ramaddr;
      resp_op.we   = ramWEN;
      resp_op.data = ramstore;
      ram_log.push_back(resp_op);
    end
  end

  task automatic wait_hit(input int max_cyc, output int ncyc, output logic ih, output logic dh);
    ncyc = 0;
    ih   = 1'b0;
    dh   = 1'b0;
    while (ncyc < max_cyc) begin
      @(negedge CLK);
      ncyc++;
      if (ihit || dhit) begin
        ih = ihit;
        dh = dhit;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({ihit, dhit, ramREN, ramWEN, halted, mem_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {ihit, dhit, ramREN, ramWEN, halted, mem_err});
    end
    n_vec++;
    if (imemload !== 32'h0) begin n_bad++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    n_vec++;
    if (dmemload !== 32'h0) begin n_bad++; $display("FAIL reset_dmemload: got %h want 0", dmemload); end
    n_vec++;
    if ({ramaddr, ramstore} !== 64'h0) begin
      n_bad++; $display("FAIL reset_ramaddr_store: got %h/%h want 0/0", ramaddr, ramstore);
    end
    nRST = 1'b0;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0) begin
      n_bad++; $display("FAIL reset_idle: got %b want 0000", {ramREN, ramWEN, ihit, dhit});
    end
    model_last_data = 1'b0;
    model_iload     = 32'h0;
    model_dload     = 32'h0;
  endtask

  task automatic test_zero_wait_fetch();
    ram_log.delete();
    ram_wait = 0;
    ram_mem[32'h40] = 32'h8C22_0004;
    ref_mem[32'h40] = 32'h8C22_0004;
    imemaddr = 32'h40;
    imemREN  = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, ramWEN, ramaddr, ihit} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      n_bad++; $display("FAIL zw_strobe: got ren=%b wen=%b addr=%h ihit=%b want 1 0 00000040 0", ramREN, ramWEN, ramaddr, ihit);
    end
    @(negedge CLK);
    n_vec++;
    if ({ihit, dhit, ramREN} !== 3'b100) begin
      n_bad++; $display("FAIL zw_hit: got ihit=%b dhit=%b ren=%b want 1 0 0", ihit, dhit, ramREN);
    end
    n_vec++;
    if (imemload !== 32'h8C22_0004) begin n_bad++; $display("FAIL zw_data: got %h want 8c220004", imemload); end
    // request still held through the response edge must not be re-granted
    @(posedge CLK);
    #1 imemREN = 1'b0;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, ihit, ram_log.size() == 1} !== 3'b001) begin
      n_bad++; $display("FAIL zw_no_regrant: got ren=%b ihit=%b ops=%0d want 0 0 1", ramREN, ihit, ram_log.size());
    end
    model_last_data = 1'b0;
    model_iload     = 32'h8C22_0004;
  endtask

  task automatic test_load_with_fetch();
    int   ncyc;
    logic ih, dh;
    ram_log.delete();
    ram_wait = 3;
    ram_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dmemaddr = 32'h100; dmemREN = 1'b1;
    imemaddr = 32'h44;  imemREN = 1'b1;
    wait_hit(12, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b01 || ncyc != 5) begin
      n_bad++; $display("FAIL lf_data_first: got ihit=%b dhit=%b cyc=%0d want 0 1 5", ih, dh, ncyc);
    end
    n_vec++;
    if (dmemload !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lf_dmemload: got %h want deadbeef", dmemload); end
    dmemREN     = 1'b0;
    model_dload = 32'hDEAD_BEEF;
    wait_hit(12, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b10 || ncyc != 6) begin
      n_bad++; $display("FAIL lf_fetch_second: got ihit=%b dhit=%b gap=%0d want 1 0 6", ih, dh, ncyc);
    end
    n_vec++;
    if (imemload !== ref_read(32'h44)) begin n_bad++; $display("FAIL lf_imemload: got %h want %h", imemload, ref_read(32'h44)); end
    n_vec++;
    if (ram_log.size() != 2 || ram_log[0].addr !== 32'h100 || ram_log[1].addr !== 32'h44) begin
      n_bad++; $display("FAIL lf_ram_order: got %0d ops want 2 ops 00000100 then 00000044", ram_log.size());
    end
    imemREN = 1'b0;
    @(negedge CLK);
    model_last_data = 1'b0;
    model_iload     = ref_read(32'h44);
  endtask

  task automatic test_store();
    int   ncyc;
    logic ih, dh;
    ram_log.delete();
    ram_wait  = 2;
    dmemaddr  = 32'h200;
    dmemstore = 32'h1234_5678;
    dmemWEN   = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'h1234_5678}) begin
      n_bad++; $display("FAIL st_strobe: got wen=%b ren=%b addr=%h data=%h want 1 0 00000200 12345678", ramWEN, ramREN, ramaddr, ramstore);
    end
    @(negedge CLK);
    n_vec++;
    if (ramWEN !== 1'b1) begin n_bad++; $display("FAIL st_hold: got wen=%b want 1", ramWEN); end
    wait_hit(8, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b01 || ncyc != 2) begin
      n_bad++; $display("FAIL st_hit: got ihit=%b dhit=%b cyc=%0d want 0 1 2", ih, dh, ncyc);
    end
    n_vec++;
    if (dmemload !== model_dload) begin n_bad++; $display("FAIL st_dmemload_kept: got %h want %h", dmemload, model_dload); end
    ref_mem[32'h200] = 32'h1234_5678;
    n_vec++;
    if (ram_mem[32'h200] !== 32'h1234_5678) begin
      n_bad++; $display("FAIL st_ram_written: got %h want 12345678", ram_mem[32'h200]);
    end
    dmemWEN = 1'b0;
    @(negedge CLK);
    model_last_data = 1'b1;
  endtask

  task automatic test_random();
    int      kind, nacc, ncyc, exp_lat;
    logic    ih, dh, exp_d, first_d, want_i, want_d, d_we;
    logic [31:0] ia, da, ds;
    ram_op_t op;
    ram_errs = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind    = $urandom_range(0, 4);
      want_i  = (kind == 0) || (kind >= 3);
      want_d  = (kind != 0);
      d_we    = (kind == 2) || (kind == 4);
      ia      = 32'($urandom_range(0, 31)) << 2;
      da      = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      ds      = $urandom;
      ram_wait = $urandom_range(0, TO - 1);
      first_d = (want_i && want_d) ? !model_last_data : want_d;
      nacc    = (want_i && want_d) ? 2 : 1;
      ram_log.delete();
      imemaddr  = ia;
      imemREN   = want_i;
      dmemaddr  = da;
      dmemstore = ds;
      dmemREN   = want_d && !d_we;
      dmemWEN   = want_d && d_we;
      for (int k = 0; k < nacc; k++) begin
        exp_d   = (k == 0) ? first_d : !first_d;
        exp_lat = ram_wait + ((k == 0) ? 2 : 3);
        wait_hit(TO + 6, ncyc, ih, dh);
        n_vec++;
        if ({ih, dh} !== {!exp_d, exp_d}) begin
          n_bad++; $display("FAIL rnd_order it=%0d k=%0d: got ihit=%b dhit=%b want %b %b", it, k, ih, dh, !exp_d, exp_d);
        end
        n_vec++;
        if (ncyc != exp_lat) begin
          n_bad++; $display("FAIL rnd_latency it=%0d k=%0d: got %0d want %0d", it, k, ncyc, exp_lat);
        end
        if (exp_d) begin
          if (d_we) ref_mem[da] = ds;
          else      model_dload = ref_read(da);
        end else begin
          model_iload = ref_read(ia);
        end
        n_vec++;
        if (imemload !== model_iload) begin
          n_bad++; $display("FAIL rnd_imemload it=%0d: got %h want %h", it, imemload, model_iload);
        end
        n_vec++;
        if (dmemload !== model_dload) begin
          n_bad++; $display("FAIL rnd_dmemload it=%0d: got %h want %h", it, dmemload, model_dload);
        end
        n_vec++;
        if (ram_log.size() != 1) begin
          n_bad++; $display("FAIL rnd_ramop_count it=%0d: got %0d want 1", it, ram_log.size());
        end else begin
          op = ram_log.pop_front();
          if (op.addr !== (exp_d ? da : ia) || op.we !== (exp_d && d_we) || (exp_d && d_we && op.data !== ds)) begin
            n_bad++; $display("FAIL rnd_ramop it=%0d: got addr=%h we=%b data=%h want addr=%h we=%b data=%h",
                              it, op.addr, op.we, op.data, exp_d ? da : ia, exp_d && d_we, ds);
          end
        end
        if (exp_d) begin
          dmemREN = 1'b0;
          dmemWEN = 1'b0;
        end else begin
          imemREN = 1'b0;
        end
        model_last_data = exp_d;
      end
      @(negedge CLK);
      n_vec++;
      if ({ihit, dhit, ramREN, ramWEN} !== 4'b0) begin
        n_bad++; $display("FAIL rnd_single_pulse it=%0d: got %b want 0000", it, {ihit, dhit, ramREN, ramWEN});
      end
    end
    n_vec++;
    if (mem_err !== 1'b0) begin n_bad++; $display("FAIL rnd_no_err: got %b want 0", mem_err); end
    ram_errs = 1'b0;
  endtask

  task automatic test_timeout();
    int   ncyc;
    logic ih, dh;
    ram_log.delete();
    ram_wait = 1000;
    imemaddr = 32'h80;
    imemREN  = 1'b1;
    wait_hit(TO + 6, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b10 || ncyc != TO + 1) begin
      n_bad++; $display("FAIL to_hit: got ihit=%b dhit=%b cyc=%0d want 1 0 %0d", ih, dh, ncyc, TO + 1);
    end
    n_vec++;
    if ({mem_err, imemload} !== {1'b1, 32'hBAD1_BAD1}) begin
      n_bad++; $display("FAIL to_err_word: got err=%b load=%h want 1 bad1bad1", mem_err, imemload);
    end
    n_vec++;
    if (ram_log.size() != 0) begin n_bad++; $display("FAIL to_no_access: got %0d ops want 0", ram_log.size()); end
    imemREN = 1'b0;
    @(negedge CLK);
    model_last_data = 1'b0;
    model_iload     = 32'hBAD1_BAD1;
    ram_wait = 1;
    dmemaddr = 32'h100;
    dmemREN  = 1'b1;
    wait_hit(TO + 6, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b01 || ncyc != 3 || dmemload !== ref_read(32'h100)) begin
      n_bad++; $display("FAIL to_recover: got dhit=%b cyc=%0d load=%h want 1 3 %h", dh, ncyc, dmemload, ref_read(32'h100));
    end
    n_vec++;
    if (mem_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", mem_err); end
    dmemREN = 1'b0;
    @(negedge CLK);
    model_last_data = 1'b1;
    model_dload     = ref_read(32'h100);
  endtask

  task automatic test_reset_mid_access();
    logic saw;
    ram_wait  = 1000;
    dmemaddr  = 32'h300;
    dmemstore = 32'hCAFE_F00D;
    dmemWEN   = 1'b1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if (ramWEN !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got wen=%b want 1", ramWEN); end
    #1 nRST = 1'b1;
    #1;
    n_vec++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'h0) begin
      n_bad++; $display("FAIL rm_strobes: got ren=%b wen=%b addr=%h data=%h want all 0", ramREN, ramWEN, ramaddr, ramstore);
    end
    n_vec++;
    if ({ihit, dhit, halted, mem_err, imemload, dmemload} !== 68'h0) begin
      n_bad++; $display("FAIL rm_outputs: got hits=%b%b halted=%b err=%b il=%h dl=%h want all 0",
                        ihit, dhit, halted, mem_err, imemload, dmemload);
    end
    dmemWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    saw  = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      saw = saw | dhit | ihit | ramWEN | ramREN;
    end
    n_vec++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL rm_abandoned: got activity=%b want 0", saw); end
    model_last_data = 1'b0;
    model_iload     = 32'h0;
    model_dload     = 32'h0;
  endtask

  task automatic test_halt();
    int   ncyc, cyc;
    logic ih, dh, saw, lost;
    ram_wait = 2;
    dmemaddr = 32'h120;
    dmemREN  = 1'b1;
    @(negedge CLK);
    halt = 1'b1;
    n_vec++;
    if (ramREN !== 1'b1) begin n_bad++; $display("FAIL h_inflight: got ren=%b want 1", ramREN); end
    wait_hit(8, ncyc, ih, dh);
    n_vec++;
    if ({ih, dh} !== 2'b01 || ncyc != 3 || dmemload !== ref_read(32'h120) || halted !== 1'b0) begin
      n_bad++; $display("FAIL h_completes: got dhit=%b cyc=%0d load=%h halted=%b want 1 3 %h 0",
                        dh, ncyc, dmemload, ref_read(32'h120), halted);
    end
    dmemREN = 1'b0;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 5) begin
      @(negedge CLK);
      cyc++;
    end
    n_vec++;
    if (halted !== 1'b1 || cyc != 2) begin
      n_bad++; $display("FAIL h_enter: got halted=%b after %0d cycles want 1 after 2", halted, cyc);
    end
    imemaddr = 32'h40;
    imemREN  = 1'b1;
    dmemWEN  = 1'b1;
    saw  = 1'b0;
    lost = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 2) halt = 1'b0;
      saw  = saw | ramREN | ramWEN | ihit | dhit;
      lost = lost | ~halted;
    end
    n_vec++;
    if (saw !== 1'b0) begin n_bad++; $display("FAIL h_ignores_requests: got activity=%b want 0", saw); end
    n_vec++;
    if (lost !== 1'b0) begin n_bad++; $display("FAIL h_terminal: got left_halt=%b want 0", lost); end
    imemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  initial begin
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    imemaddr = 32'h0; dmemaddr = 32'h0; dmemstore = 32'h0;
    test_reset();
    test_zero_wait_fetch();
    test_load_with_fetch();
    test_store();
    test_random();
    test_timeout();
    test_reset_mid_access();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "bench timed out");
  end

endmodule
